// File: rtl/s2p_symbol_packer.sv
// Serial-to-parallel QAM symbol packer: frames a bit stream into BITS_PER_SYM-bit symbols
// and queues them in a small FIFO, splitting each head symbol into in-phase/quadrature halves.
module s2p_symbol_packer #(
  parameter int unsigned BITS_PER_SYM = 4,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic                        sym_align,
  input  logic                        ovf_clear,
  input  logic                        sym_ready,
  output logic                        sym_valid,
  output logic [BITS_PER_SYM/2-1:0]   sym_i,
  output logic [BITS_PER_SYM/2-1:0]   sym_q,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic                        overflow
);

  localparam int unsigned CW = $clog2(BITS_PER_SYM);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned HW = BITS_PER_SYM / 2;
  localparam logic [CW-1:0] LastIdx   = CW'(BITS_PER_SYM - 1);
  localparam logic [PW:0]   FullCount = DEPTH[PW:0];

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] shreg_q, shreg_d;
  logic [BITS_PER_SYM-1:0] mem_q [DEPTH];
  logic [BITS_PER_SYM-1:0] mem_d [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic [CW-1:0]           cur_idx;
  logic [CW-1:0]           bit_pos;
  logic [BITS_PER_SYM-1:0] word;
  logic [BITS_PER_SYM-1:0] head;
  logic                    push, push_ok, pop, full, drop;

  // Framing: an aligned bit restarts the symbol as bit 0 with the partial word dropped.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    word    = '0;
    cur_idx = sym_align ? '0 : cnt_q;
    bit_pos = (MSB_FIRST != 0) ? (LastIdx - cur_idx) : cur_idx;
    if (bit_valid) begin
      word = sym_align ? '0 : shreg_q;
      for (int i = 0; i < BITS_PER_SYM; i++) begin
        if (CW'(i) == bit_pos) word[i] = bit_in;
      end
      if (cur_idx == LastIdx) begin
        push    = 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        cnt_d   = cur_idx + CW'(1);
        shreg_d = word;
      end
    end else if (sym_align) begin
      cnt_d   = '0;
      shreg_d = '0;
    end
  end

  // FIFO: a pop frees the slot the same cycle, so a push into a full FIFO is accepted then.
  always_comb begin
    full      = (count_q == FullCount);
    sym_valid = (count_q != '0);
    pop       = sym_valid & sym_ready;
    push_ok   = push & (~full | pop);
    drop      = push & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (PW+1)'(1);
    end

    // A drop wins over a coincident clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    sym_i      = sym_valid ? head[BITS_PER_SYM-1:HW] : '0;
    sym_q      = sym_valid ? head[HW-1:0] : '0;
    fill_level = count_q;
    overflow   = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
